dlfloat_dot_sched: RTL and testbench



---
 rtl/dlfloat_pkg.sv | 16 +
 rtl/dlf_down_ctr.sv | 31 +++
 rtl/dlfloat_dot_sched.sv | 180 ++++++++++++++++++
 tb/tb_dlfloat_dot_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat constants and the dot-product scheduler state encoding.
package dlfloat_pkg;

  localparam int DLF_W = 16;
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
  localparam logic [DLF_W-1:0] DLF_ONE  = 16'h3E00;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/dlf_down_ctr.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
module dlf_down_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dlfloat_dot_sched.sv
// Dot-product sequencer feeding the DLFloat MAC and capturing its result.
// Optional FEED stall timeout with err output: define DLF_DOT_TIMEOUT_EN.
module dlfloat_dot_sched
  import dlfloat_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 3
`ifdef DLF_DOT_TIMEOUT_EN
  ,
  parameter int TMO_CYC = 255
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DLF_W-1:0] in_a,
  input  logic [DLF_W-1:0] in_b,
  output logic [DLF_W-1:0] mac_a,
  output logic [DLF_W-1:0] mac_b,
  output logic             mac_clr,
  input  logic [DLF_W-1:0] mac_c,
  output logic [DLF_W-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
`ifdef DLF_DOT_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  localparam int DRN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  sched_state_t     state_q, state_d;
  logic [DLF_W-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic [DLF_W-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             accept, rem_load, drn_load, drn_dec;
  logic [LEN_W-1:0] rem_cnt;
  logic [DRN_W-1:0] drn_cnt;
  logic             rem_zero, drn_zero;

`ifdef DLF_DOT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] idle_q, idle_d;
  logic             err_q, err_d;
`endif

  assign in_ready = (state_q == FEED);
  assign mac_clr  = (state_q == CLEAR);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid && in_ready;

  dlf_down_ctr #(.W(LEN_W)) u_rem_ctr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (rem_load),
    .load_val_i(len),
    .dec_i     (accept),
    .cnt_o     (rem_cnt),
    .zero_o    (rem_zero)
  );

  dlf_down_ctr #(.W(DRN_W)) u_drn_ctr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (drn_load),
    .load_val_i(DRN_W'(MAC_LAT)),
    .dec_i     (drn_dec),
    .cnt_o     (drn_cnt),
    .zero_o    (drn_zero)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    mac_a_d     = DLF_ZERO;
    mac_b_d     = DLF_ZERO;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    rem_load    = 1'b0;
    drn_load    = 1'b0;
    drn_dec     = 1'b0;
`ifdef DLF_DOT_TIMEOUT_EN
    idle_d      = '0;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            rem_load = 1'b1;
            state_d  = CLEAR;
          end else begin
            res_d       = DLF_ZERO;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      CLEAR: state_d = FEED;
      FEED: begin
        if (accept) begin
          mac_a_d = in_a;
          mac_b_d = in_b;
          if (!rem_zero && rem_cnt == LEN_W'(1)) begin
            drn_load = 1'b1;
            state_d  = DRAIN;
          end
        end
`ifdef DLF_DOT_TIMEOUT_EN
        else if (idle_q == TMO_W'(TMO_CYC - 1)) begin
          err_d       = 1'b1;
          res_d       = mac_c;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idle_d = idle_q + TMO_W'(1);
        end
`endif
      end
      DRAIN: begin
        if (drn_zero) begin
          res_d       = mac_c;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          drn_dec = 1'b1;
        end
      end
      DONE: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef DLF_DOT_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it only takes effect on a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mac_a_q     <= DLF_ZERO;
      mac_b_q     <= DLF_ZERO;
      res_q       <= DLF_ZERO;
      res_valid_q <= 1'b0;
`ifdef DLF_DOT_TIMEOUT_EN
      idle_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
`ifdef DLF_DOT_TIMEOUT_EN
      idle_q      <= idle_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;
`ifdef DLF_DOT_TIMEOUT_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_dlfloat_dot_sched.sv
// Self-checking bench: real-valued MAC model, random and directed dot-product jobs.
module tb_dlfloat_dot_sched;
  import dlfloat_pkg::*;

  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 3;
  localparam int TMO     = 8;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_ready, mac_clr, res_valid, res_ready, busy;
  logic [LEN_W-1:0] len;
  logic [15:0]      in_a, in_b, mac_a, mac_b, mac_c, res;
`ifdef DLF_DOT_TIMEOUT_EN
  logic             err;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  int clr_cnt  = 0;
  int ir_cnt   = 0;
  bit job_on   = 1'b0;
  bit busy_drop = 1'b0;
  logic [15:0] vals [6];
  logic [15:0] dir_a [16];
  logic [15:0] dir_b [16];

  dlfloat_dot_sched #(
    .LEN_W  (LEN_W),
    .MAC_LAT(MAC_LAT)
`ifdef DLF_DOT_TIMEOUT_EN
    , .TMO_CYC(TMO)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_clr  (mac_clr),
    .mac_c    (mac_c),
    .res      (res),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy)
`ifdef DLF_DOT_TIMEOUT_EN
    , .err    (err)
`endif
  );

  always #5 clk = ~clk;

  function automatic real from_dlf(input logic [15:0] x);
    real r;
    int  e;
    if (x[14:9] == 6'd0) return 0.0;
    r = 1.0 + real'(x[8:0]) / 512.0;
    e = int'(x[14:9]) - 31;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[15] ? -r : r;
  endfunction

  function automatic logic [15:0] to_dlf(input real v);
    logic s;
    int   e, mi;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    if (s) v = -v;
    e = 31;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    mi = int'((v - 1.0) * 512.0);
    if (mi == 512) begin mi = 0; e++; end
    return {s, e[5:0], mi[8:0]};
  endfunction

  // MAC model: product enters the accumulator one edge after presentation,
  // visible on mac_c MAC_LAT edges after presentation.
  real acc;
  logic [15:0] acc_d1;
  always @(posedge clk) begin
    if (rst || mac_clr) acc <= 0.0;
    else                acc <= acc + from_dlf(mac_a) * from_dlf(mac_b);
    acc_d1 <= to_dlf(acc);
    mac_c  <= acc_d1;
  end

  always @(negedge clk) begin
    if (mac_clr)  clr_cnt++;
    if (in_ready) ir_cnt++;
    if (job_on && !busy) busy_drop = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // gap < 0: random 0..2 idle cycles before each pair; else that fixed gap between pairs.
  task automatic run_job(input int n, input int gap, input int hold, input bit poke, input bit use_dir);
    real sum;
    int  clr0, ir0, lat, g;
    logic [15:0] a, b, exp_res;
    sum  = 0.0;
    clr0 = clr_cnt;
    ir0  = ir_cnt;
    busy_drop = 1'b0;
    start = 1'b1;
    len   = n[LEN_W-1:0];
    @(negedge clk);
    start  = 1'b0;
    job_on = 1'b1;
    if (n == 0) begin
      check("zero_valid", res_valid, 1);
    end else begin
      check("clr_strobe", mac_clr, 1);
      check("clr_ready", in_ready, 0);
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        g = (gap < 0) ? $urandom_range(0, 2) : ((i == 0) ? 0 : gap);
        repeat (g) begin
          in_valid = 1'b0;
          check("gap_ready", in_ready, 1);
          @(negedge clk);
          check("gap_mac_a", mac_a, 0);
          check("gap_mac_b", mac_b, 0);
        end
        a = use_dir ? dir_a[i] : vals[$urandom_range(0, 5)];
        b = use_dir ? dir_b[i] : vals[$urandom_range(0, 5)];
        sum += from_dlf(a) * from_dlf(b);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        check("feed_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("mac_a", mac_a, a);
        check("mac_b", mac_b, b);
      end
      lat = 0;
      while (!res_valid && lat < 64) begin
        @(negedge clk);
        lat++;
        if (!res_valid) check("drain_mac_a", mac_a, 0);
      end
      check("latency", lat, MAC_LAT + 1);
      check("clr_pulses", clr_cnt - clr0, 1);
    end
    exp_res = to_dlf(sum);
    check("res", res, exp_res);
    repeat (hold) begin
      if (poke) begin start = 1'b1; len = 3; end
      @(negedge clk);
      start = 1'b0;
      check("hold_res", res, exp_res);
      check("hold_valid", res_valid, 1);
      check("hold_busy", busy, 1);
    end
    if (n == 0) begin
      check("zero_no_clr", clr_cnt - clr0, 0);
      check("zero_no_ready", ir_cnt - ir0, 0);
    end
    job_on    = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("hs_valid", res_valid, 0);
    check("hs_busy", busy, 0);
    check("busy_held", busy_drop, 0);
    @(negedge clk);
    check("idle_after", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vals = '{16'h3E00, 16'h4000, 16'h3C00, 16'hBE00, 16'h3F00, 16'h0000};
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_clr", mac_clr, 0);
    check("rst_res", res, 0);
    check("rst_valid", res_valid, 0);
    check("rst_mac_a", mac_a, 0);

    // 4 x (1.0 * 1.0), back to back
    for (int i = 0; i < 16; i++) begin dir_a[i] = DLF_ONE; dir_b[i] = DLF_ONE; end
    run_job(4, 0, 0, 1'b0, 1'b1);
    check("dir_4p0", res, 16'h4200);

    // 3 x (2.0 * 1.0) with two idle cycles between pairs
    for (int i = 0; i < 3; i++) dir_a[i] = 16'h4000;
    run_job(3, 2, 1, 1'b0, 1'b1);
    check("dir_6p0", res, to_dlf(6.0));

    run_job(0, 0, 0, 1'b0, 1'b0);
    check("zero_res_after", res, 0);

    // result held for 10 cycles while start is pulsed
    for (int i = 0; i < 3; i++) dir_a[i] = DLF_ONE;
    run_job(2, 0, 10, 1'b1, 1'b1);

    // reset in the middle of FEED after two of five accepts
    start = 1'b1; len = 5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_a = DLF_ONE; in_b = DLF_ONE;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_ready", in_ready, 0);
    check("mrst_clr", mac_clr, 0);
    check("mrst_mac_a", mac_a, 0);
    check("mrst_mac_b", mac_b, 0);
    check("mrst_res", res, 0);
    check("mrst_valid", res_valid, 0);
    run_job(1, 0, 0, 1'b0, 1'b1);
    check("after_rst_res", res, DLF_ONE);

    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 8), -1, $urandom_range(0, 3), 1'b0, 1'b0);

`ifdef DLF_DOT_TIMEOUT_EN
    begin
      int lat;
      start = 1'b1; len = 2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'h4000; in_b = DLF_ONE;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 64) begin
        @(negedge clk);
        lat++;
      end
      check("tmo_latency", lat, TMO);
      check("tmo_err", err, 1);
      check("tmo_res", res, 16'h4000);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("tmo_err_clr", err, 0);
      check("tmo_idle", busy, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
